piso_serializer: RTL and testbench

//  Parallel-in serial-out transmitter: the sending end of our serial shift links.

---
 rtl/piso_pkg.sv | 12 +
 rtl/piso_serializer_if.sv | 25 ++
 rtl/piso_bit_counter.sv | 32 +++
 rtl/piso_serializer.sv | 105 ++++++++++
 tb/tb_piso_serializer.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/piso_pkg.sv
// Shared types and constants for the parallel-in serial-out transmitter.
package piso_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } piso_state_t;

  localparam int DIR_LSB_FIRST = 0;
  localparam int DIR_MSB_FIRST = 1;

endpackage

// File: rtl/piso_serializer_if.sv
// Producer-side load handshake plus serial channel signals of the PISO transmitter.
interface piso_serializer_if #(
  parameter int WIDTH = 4
);

  logic [WIDTH-1:0] load_data;
  logic             load_valid;
  logic             load_ready;
  logic             shift_en;
  logic             sout;
  logic             sout_valid;
  logic             sout_last;
  logic             busy;

  modport master (
    output load_data, load_valid, shift_en,
    input  load_ready, sout, sout_valid, sout_last, busy
  );

  modport slave (
    input  load_data, load_valid, shift_en,
    output load_ready, sout, sout_valid, sout_last, busy
  );

endinterface

// File: rtl/piso_bit_counter.sv
// Bit position counter: cleared on each load, advanced per shifted bit,
// flags the final bit position of the word.
module piso_bit_counter #(
  parameter int WIDTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic terminal
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [CW-1:0] count_r;

  // Position register; a load restarts the count even on the last-bit edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= '0;
    end else if (clear) begin
      count_r <= '0;
    end else if (enable) begin
      count_r <= count_r + CW'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign terminal = (count_r == CW'(WIDTH - 1));

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in serial-out transmitter: accepts a word on valid/ready and
// shifts it out one bit per enabled clock, LSB or MSB first.
module piso_serializer
  import piso_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int MSB_FIRST = DIR_LSB_FIRST
) (
  input  logic             clk,
  input  logic             rst_n,
  piso_serializer_if.slave bus
);

  piso_state_t      state_r;
  piso_state_t      state_s;
  logic [WIDTH-1:0] shreg_r;
  logic [WIDTH-1:0] shifted_s;
  logic             in_shift_s;
  logic             advance_s;
  logic             term_s;
  logic             last_s;
  logic             ready_s;
  logic             accept_s;
  logic             head_bit_s;

  assign in_shift_s = (state_r == SHIFT);
  assign advance_s  = in_shift_s & bus.shift_en;
  assign last_s     = in_shift_s & term_s;
  assign ready_s    = (state_r == IDLE) | (last_s & bus.shift_en);
  assign accept_s   = bus.load_valid & ready_s;

  piso_bit_counter #(
    .WIDTH (WIDTH)
  ) u_bit_counter (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (accept_s),
    .enable   (advance_s),
    .terminal (term_s)
  );

  // Next-state logic; a load on the final bit keeps the FSM in SHIFT.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_s = SHIFT;
        end else begin
          state_s = IDLE;
        end
      end
      SHIFT: begin
        if (advance_s && term_s) begin
          state_s = accept_s ? SHIFT : IDLE;
        end else begin
          state_s = SHIFT;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Zero-fill shift in the configured direction; the head bit is the one on sout.
  always_comb begin
    shifted_s  = shreg_r;
    head_bit_s = 1'b0;
    if (MSB_FIRST == DIR_MSB_FIRST) begin
      shifted_s  = {shreg_r[WIDTH-2:0], 1'b0};
      head_bit_s = shreg_r[WIDTH-1];
    end else begin
      shifted_s  = {1'b0, shreg_r[WIDTH-1:1]};
      head_bit_s = shreg_r[0];
    end
  end

  // Shift register: load wins over shift so back-to-back words have no bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg_r <= '0;
    end else if (accept_s) begin
      shreg_r <= bus.load_data;
    end else if (advance_s) begin
      shreg_r <= shifted_s;
    end else begin
      shreg_r <= shreg_r;
    end
  end

  assign bus.load_ready = ready_s;
  assign bus.sout       = in_shift_s & head_bit_s;
  assign bus.sout_valid = in_shift_s;
  assign bus.sout_last  = last_s;
  assign bus.busy       = in_shift_s;

endmodule

// File: tb/tb_piso_serializer.sv
// Drives an LSB-first and an MSB-first serializer with shared stimulus and
// compares them against a bit-queue reference model and a shift-right receiver.
module tb_piso_serializer;
  import piso_pkg::*;

  localparam int W = 4;

  logic clk;
  logic rst_n;

  piso_serializer_if #(.WIDTH(W)) b0 ();
  piso_serializer_if #(.WIDTH(W)) b1 ();

  piso_serializer #(.WIDTH(W), .MSB_FIRST(DIR_LSB_FIRST)) dut_lsb (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b0.slave)
  );

  piso_serializer #(.WIDTH(W), .MSB_FIRST(DIR_MSB_FIRST)) dut_msb (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b1.slave)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: pending serial bits per DUT, words in flight, receiver.
  logic         q0[$];
  logic         q1[$];
  logic [W-1:0] words[$];
  logic [W-1:0] rx;
  logic         s_sout0;
  logic         acc;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic set_inputs(input logic v, input logic [W-1:0] d, input logic en);
    b0.load_valid = v;  b0.load_data = d;  b0.shift_en = en;
    b1.load_valid = v;  b1.load_data = d;  b1.shift_en = en;
  endtask

  task automatic model_reset();
    q0.delete();
    q1.delete();
    words.delete();
    rx = '0;
  endtask

  // Advance the model across one rising edge with the given inputs.
  task automatic model_edge(input logic v, input logic [W-1:0] d, input logic en);
    logic rdy;
    logic [W-1:0] exp_word;
    rdy = (q0.size() == 0) || (q0.size() == 1 && en);
    acc = v && rdy;
    if (en && q0.size() > 0) begin
      rx = {s_sout0, rx[W-1:1]};
      if (q0.size() == 1) begin
        exp_word = words.pop_front();
        check("rx_word", 32'(rx), 32'(exp_word));
      end
      void'(q0.pop_front());
      void'(q1.pop_front());
    end
    if (acc) begin
      for (int i = 0; i < W; i++) begin
        q0.push_back(d[i]);
        q1.push_back(d[W-1-i]);
      end
      words.push_back(d);
    end
  endtask

  task automatic drive_cycle(input logic v, input logic [W-1:0] d, input logic en);
    logic e_valid;
    logic e_last;
    logic e_ready;
    @(negedge clk);
    set_inputs(v, d, en);
    #1;
    e_valid = (q0.size() > 0);
    e_last  = (q0.size() == 1);
    e_ready = (q0.size() == 0) || (q0.size() == 1 && en);
    check("lsb_sout",   32'(b0.sout),       32'(e_valid ? q0[0] : 1'b0));
    check("lsb_valid",  32'(b0.sout_valid), 32'(e_valid));
    check("lsb_last",   32'(b0.sout_last),  32'(e_last));
    check("lsb_busy",   32'(b0.busy),       32'(e_valid));
    check("lsb_ready",  32'(b0.load_ready), 32'(e_ready));
    check("msb_sout",   32'(b1.sout),       32'(e_valid ? q1[0] : 1'b0));
    check("msb_valid",  32'(b1.sout_valid), 32'(e_valid));
    check("msb_last",   32'(b1.sout_last),  32'(e_last));
    check("msb_ready",  32'(b1.load_ready), 32'(e_ready));
    s_sout0 = b0.sout;
    @(posedge clk);
    model_edge(v, d, en);
  endtask

  task automatic async_reset();
    @(negedge clk);
    set_inputs(1'b0, '0, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_sout",  32'(b0.sout),       32'(1'b0));
    check("rst_valid", 32'(b0.sout_valid), 32'(1'b0));
    check("rst_busy",  32'(b0.busy),       32'(1'b0));
    check("rst_last",  32'(b1.sout_last),  32'(1'b0));
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_ready", 32'(b0.load_ready), 32'(1'b1));
  endtask

  initial begin
    logic         pv;
    logic [W-1:0] pd;
    int           tries;
    rst_n = 1'b0;
    set_inputs(1'b0, '0, 1'b0);
    model_reset();
    s_sout0 = 1'b0;
    acc     = 1'b0;
    #12;
    rst_n = 1'b1;

    // Idle state after reset.
    repeat (2) drive_cycle(1'b0, 4'h0, 1'b1);

    // Single word 1101, then idle.
    drive_cycle(1'b1, 4'b1101, 1'b1);
    repeat (6) drive_cycle(1'b0, 4'h0, 1'b1);

    // Back-to-back A then 5 with valid held.
    drive_cycle(1'b1, 4'hA, 1'b1);
    tries = 0;
    acc   = 1'b0;
    while (!acc && tries < 8) begin
      drive_cycle(1'b1, 4'h5, 1'b1);
      tries++;
    end
    check("b2b_accept", 32'(acc), 32'(1'b1));
    check("b2b_gap", 32'(tries), 32'(W));
    repeat (5) drive_cycle(1'b0, 4'h0, 1'b1);

    // Stall after bit 1 of 0110, then stall on the last bit with a word pending.
    drive_cycle(1'b1, 4'b0110, 1'b1);
    drive_cycle(1'b0, 4'h0, 1'b1);
    repeat (3) drive_cycle(1'b1, 4'h9, 1'b0);
    drive_cycle(1'b0, 4'h0, 1'b1);
    drive_cycle(1'b0, 4'h0, 1'b1);
    repeat (2) drive_cycle(1'b1, 4'h9, 1'b0);
    drive_cycle(1'b1, 4'h9, 1'b1);
    repeat (5) drive_cycle(1'b0, 4'h0, 1'b1);

    // 1000 exercises the MSB-first instance's single leading one.
    drive_cycle(1'b1, 4'b1000, 1'b1);
    repeat (5) drive_cycle(1'b0, 4'h0, 1'b1);

    // Abort mid-word of F, then a clean 3.
    drive_cycle(1'b1, 4'hF, 1'b1);
    drive_cycle(1'b0, 4'h0, 1'b1);
    async_reset();
    drive_cycle(1'b1, 4'h3, 1'b1);
    repeat (5) drive_cycle(1'b0, 4'h0, 1'b1);

    // Randomized traffic: producer holds each word until accepted.
    pv = 1'b0;
    pd = '0;
    for (int n = 0; n < 400; n++) begin
      if (!pv && $urandom_range(0, 2) != 0) begin
        pv = 1'b1;
        pd = W'($urandom);
      end
      drive_cycle(pv, pd, $urandom_range(0, 3) != 0);
      if (acc) pv = 1'b0;
    end
    repeat (8) drive_cycle(1'b0, 4'h0, 1'b1);
    check("drain_empty", 32'(words.size()), 32'(0));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
